// File: rtl/ppu_pkg.sv
// Shared constants for the PPU background fetch sequencer: fetch phases,
// bus base addresses and the pattern high-plane offset.
package ppu_pkg;

   localparam int unsigned V_W     = 15;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PHASE_W = 3;
   localparam int unsigned ATTR_W  = 2;

   // Two dots per fetch: address on the even dot, read/latch on the odd dot
   typedef enum logic [PHASE_W-1:0] {
      NT_0  = 3'd0,
      NT_1  = 3'd1,
      AT_0  = 3'd2,
      AT_1  = 3'd3,
      PTL_0 = 3'd4,
      PTL_1 = 3'd5,
      PTH_0 = 3'd6,
      PTH_1 = 3'd7
   } phase_e;

   localparam logic [ADDR_W-1:0] NT_BASE    = 14'h2000;
   localparam logic [ADDR_W-1:0] AT_BASE    = 14'h23C0;
   localparam logic [ADDR_W-1:0] PTH_OFFSET = 14'h0008;

endpackage

// File: rtl/ppu_bg_fetch_sequencer_if.sv
// Bus bundle between the background fetch sequencer and its environment.
interface ppu_bg_fetch_sequencer_if;
   import ppu_pkg::*;

   logic                i_ce;
   logic                i_fetch_en;
   logic [V_W-1:0]      i_v;
   logic                i_bg_table;
   logic [DATA_W-1:0]   i_data;
   logic [ADDR_W-1:0]   o_address;
   logic                o_rd;
   logic [PHASE_W-1:0]  o_phase;
   logic [DATA_W-1:0]   o_tile_id;
   logic [ATTR_W-1:0]   o_attr;
   logic [DATA_W-1:0]   o_pattern_lo;
   logic [DATA_W-1:0]   o_pattern_hi;
   logic                o_load_shifters;
   logic                o_inc_coarse_x;

   modport master (
      output i_ce, i_fetch_en, i_v, i_bg_table, i_data,
      input  o_address, o_rd, o_phase, o_tile_id, o_attr,
             o_pattern_lo, o_pattern_hi, o_load_shifters, o_inc_coarse_x
   );

   modport slave (
      input  i_ce, i_fetch_en, i_v, i_bg_table, i_data,
      output o_address, o_rd, o_phase, o_tile_id, o_attr,
             o_pattern_lo, o_pattern_hi, o_load_shifters, o_inc_coarse_x
   );

endinterface

// File: rtl/ppu_fetch_address.sv
// Combinational PPU bus address for a background fetch phase.
module ppu_fetch_address
   import ppu_pkg::*;
(
   input  logic [PHASE_W-1:0] phase,
   input  logic [V_W-1:0]     v,
   input  logic [DATA_W-1:0]  tile_id,
   input  logic               bg_table,
   output logic [ADDR_W-1:0]  address
);

   logic [ADDR_W-1:0] pt_lo_c;

   always_comb begin
      pt_lo_c = ADDR_W'({bg_table, tile_id, 1'b0, v[14:12]});
      address = NT_BASE | ADDR_W'(v[11:0]);
      case (phase)
         NT_0, NT_1:   address = NT_BASE | ADDR_W'(v[11:0]);
         // One attribute byte covers a 4x4 tile block: nametable, coarse Y/4, coarse X/4
         AT_0, AT_1:   address = AT_BASE | ADDR_W'({v[11:10], 4'b0000, v[9:7], v[4:2]});
         PTL_0, PTL_1: address = pt_lo_c;
         PTH_0, PTH_1: address = pt_lo_c | PTH_OFFSET;
         default:      address = NT_BASE | ADDR_W'(v[11:0]);
      endcase
   end

endmodule

// File: rtl/ppu_bg_fetch_sequencer.sv
// Background tile fetch sequencer: eight-dot phase counter, fetch latches
// and the shifter-load / coarse-X increment pulse.
module ppu_bg_fetch_sequencer
   import ppu_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   ppu_bg_fetch_sequencer_if.slave  bus
);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [DATA_W-1:0]  tile_id_q, tile_id_d;
   logic [ATTR_W-1:0]  attr_q, attr_d;
   logic [DATA_W-1:0]  pat_lo_q, pat_lo_d;
   logic [DATA_W-1:0]  pat_hi_q, pat_hi_d;
   logic               load_q, load_d;
   logic [ATTR_W-1:0]  attr_sel_c;
   logic [PHASE_W-1:0] addr_phase_c;

   // Quadrant of the attribute byte chosen by coarse Y bit 1 and coarse X bit 1
   always_comb begin
      attr_sel_c = bus.i_data[1:0];
      case ({bus.i_v[6], bus.i_v[1]})
         2'b00:   attr_sel_c = bus.i_data[1:0];
         2'b01:   attr_sel_c = bus.i_data[3:2];
         2'b10:   attr_sel_c = bus.i_data[5:4];
         2'b11:   attr_sel_c = bus.i_data[7:6];
         default: attr_sel_c = bus.i_data[1:0];
      endcase
   end

   // Next-state: phase advance and latching only on dot-enable edges
   always_comb begin
      phase_d   = phase_q;
      tile_id_d = tile_id_q;
      attr_d    = attr_q;
      pat_lo_d  = pat_lo_q;
      pat_hi_d  = pat_hi_q;
      load_d    = 1'b0;
      if (bus.i_ce) begin
         if (!bus.i_fetch_en) begin
            phase_d = NT_0;
         end else begin
            phase_d = PHASE_W'(phase_q + PHASE_W'(1));
            case (phase_q)
               NT_1:  tile_id_d = bus.i_data;
               AT_1:  attr_d    = attr_sel_c;
               PTL_1: pat_lo_d  = bus.i_data;
               PTH_1: begin
                  pat_hi_d = bus.i_data;
                  load_d   = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Pulse flop updates every clock so it clears even when the dot is stalled
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_q   <= NT_0;
         tile_id_q <= '0;
         attr_q    <= '0;
         pat_lo_q  <= '0;
         pat_hi_q  <= '0;
         load_q    <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         tile_id_q <= tile_id_d;
         attr_q    <= attr_d;
         pat_lo_q  <= pat_lo_d;
         pat_hi_q  <= pat_hi_d;
         load_q    <= load_d;
      end
   end

   assign addr_phase_c = bus.i_fetch_en ? phase_q : NT_0;

   ppu_fetch_address u_fetch_address (
      .phase    (addr_phase_c),
      .v        (bus.i_v),
      .tile_id  (tile_id_q),
      .bg_table (bus.i_bg_table),
      .address  (bus.o_address)
   );

   assign bus.o_rd            = bus.i_fetch_en & phase_q[0];
   assign bus.o_phase         = phase_q;
   assign bus.o_tile_id       = tile_id_q;
   assign bus.o_attr          = attr_q;
   assign bus.o_pattern_lo    = pat_lo_q;
   assign bus.o_pattern_hi    = pat_hi_q;
   assign bus.o_load_shifters = load_q;
   assign bus.o_inc_coarse_x  = load_q;

endmodule

// File: doc/ppu_bg_fetch_sequencer.md
PPU_BG_FETCH_SEQUENCER -- requirements
Module: ppu_bg_fetch_sequencer

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 i_clk  in  1  PPU master clock; all state on rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 i_ce  in  1  dot enable; one PPU dot per i_clk cycle with i_ce=1.
REQ-005 i_fetch_en  in  1  rendering enabled and current dot inside a background fetch window.
REQ-006 i_v  in  15  loopy v register: [14:12] fine Y, [11:10] nametable, [9:5] coarse Y, [4:0] coarse X.
REQ-007 i_bg_table  in  1  background pattern table select (PPUCTRL bit 4).
REQ-008 i_data  in  8  PPU bus read data, valid during read dots.
REQ-009 o_address  out  14  PPU bus address for the current dot.
REQ-010 o_rd  out  1  read strobe; high on the second dot of each fetch pair.
REQ-011 o_phase  out  3  current fetch phase 0..7.
REQ-012 o_tile_id  out  8  latched nametable byte.
REQ-013 o_attr  out  2  latched, already-selected attribute palette bits.
REQ-014 o_pattern_lo / o_pattern_hi  out  8 each  latched pattern bitplanes.
REQ-015 o_load_shifters  out  1  one-i_clk pulse: all four latches hold a complete tile.
REQ-016 o_inc_coarse_x  out  1  one-i_clk pulse, coincident with o_load_shifters, requesting coarse-X increment of v.

Function
REQ-017 State changes only on i_clk edges where i_ce=1, except the two pulse outputs (REQ-024).
REQ-018 Phase counter: i_fetch_en=0 -> phase:=0; else phase:=phase+1, wrapping 7->0.
REQ-019 Fetch pairs: phases 0-1 NT, 2-3 AT, 4-5 PT low, 6-7 PT high.
REQ-020 o_address is combinational from phase, i_v, o_tile_id, i_bg_table: NT = 0x2000 | v[11:0]; AT = 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2]; PT low = i_bg_table<<12 | tile_id<<4 | v[14:12]; PT high = PT low | 0x0008.
REQ-021 i_fetch_en=0: o_address = NT address, o_rd=0; pulses remain 0.
REQ-022 o_rd = i_fetch_en & phase[0].
REQ-023 Latching on ce edge with i_fetch_en=1: phase 1 -> o_tile_id:=i_data; phase 3 -> o_attr:=(i_data >> shift)[1:0], shift = {v[6],v[1],1'b0} (0,2,4,6); phase 5 -> o_pattern_lo:=i_data; phase 7 -> o_pattern_hi:=i_data.
REQ-024 On the phase-7 latch edge, o_load_shifters and o_inc_coarse_x go high for exactly one i_clk cycle, then clear on the next i_clk edge regardless of i_ce.
REQ-025 i_fetch_en falling mid-tile: phase to 0 on that ce edge, no latch that edge, latches keep values, no pulse; next enable restarts at NT.
REQ-026 i_v changing mid-tile is used as presented; v is not captured.

Reset
REQ-027 i_reset_n=0 asynchronously clears phase, o_tile_id, o_attr, o_pattern_lo, o_pattern_hi, o_load_shifters, o_inc_coarse_x to 0; o_address then equals 0x2000|v[11:0] and o_rd=0.
REQ-028 Reset release lets the first fetch begin at the first ce edge with i_fetch_en=1.

Structure
REQ-029 Shared package ppu_pkg holds phase constants (NT_0..PTH_1), base addresses 0x2000 and 0x23C0, and the PT-high offset 0x0008.
REQ-030 One combinational sub-module, ppu_fetch_address, maps (phase, v, tile_id, table) to o_address; the sequencer holds counter, latches and pulses.

Verification
REQ-031 Reset mid-tile at phase 5 -> all outputs 0 immediately, o_address=0x2000|v[11:0].
REQ-032 v=0x2C5A, table=1, data 0x41,0xC6,0xAA,0x55 over phases 1,3,5,7 -> addresses 0x2C5A,0x2FC6,0x1412,0x141A; tile_id=0x41, attr=3, lo=0xAA, hi=0x55; one load/inc pulse.
REQ-033 v=0x0000, table=0, 4 consecutive tiles -> NT 0x2000, AT 0x23C0 each tile; four pulses, 8 ce dots apart.
REQ-034 i_ce toggling 1 of 4 clocks -> identical sequence; each pulse exactly one i_clk long.
REQ-035 i_fetch_en dropped at phase 4 -> phase 0, o_rd=0, latches hold, no pulse; re-enable restarts at NT.
REQ-036 AT selection: data 0xE4 with {v[6],v[1]} = 00,01,10,11 -> o_attr 0,1,2,3.
